// File: rtl/regfile_sb_pkg.sv
// Shared CPU register-file types: default sizing, address type, zero register and pending vector.
package regfile_sb_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned NREG_DEFAULT = 32;

  typedef logic [$clog2(NREG_DEFAULT)-1:0] reg_addr_t;
  typedef logic [NREG_DEFAULT-1:0]         sb_vec_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_bypass.sv
// Priority match of one read address against all write ports; the highest matching port wins.
module regfile_sb_bypass #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WRITE_PORTS = 2,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic [ADDR_W-1:0]                        raddr,
  input  logic [WRITE_PORTS-1:0]                   we,
  input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]       waddr,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]   wrdata,
  output logic                                     hit,
  output logic [DATA_WIDTH-1:0]                    data
);

  // Ascending scan so later (higher-index) matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
      if (we[j] && (waddr[j] == raddr) && (raddr != '0)) begin
        hit  = 1'b1;
        data = wrdata[j];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-through bypass and a per-register pending scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = XLEN,
  parameter int unsigned N_REG         = NREG_DEFAULT,
  parameter int unsigned WRITE_PORTS   = 2,
  parameter int unsigned READ_PORTS    = 4,
  parameter int unsigned WRITE_THROUGH = 1,
  parameter int unsigned ISSUE_PORTS   = 1,
  localparam int unsigned ADDR_W       = $clog2(N_REG)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [WRITE_PORTS-1:0]                 we,
  input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]     waddr,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wrdata,
  input  logic [READ_PORTS-1:0][ADDR_W-1:0]      raddr,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rddata,
  output logic [READ_PORTS-1:0]                  rd_busy,
  input  logic [ISSUE_PORTS-1:0]                 iss_valid,
  input  logic [ISSUE_PORTS-1:0][ADDR_W-1:0]     iss_addr,
  input  logic                                   flush
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs_q [N_REG];
  logic [DATA_WIDTH-1:0] regs_d [N_REG];
  logic [N_REG-1:0]      pend_q, pend_d;

  always_comb begin
    regs_d = regs_q;
    for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
      if (we[j] && (waddr[j] != ZeroAddr)) begin
        regs_d[waddr[j]] = wrdata[j];
      end
    end
  end

  // Release first, then reserve: a new producer supersedes a same-cycle writeback.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
      if (we[j]) pend_d[waddr[j]] = 1'b0;
    end
    for (int unsigned k = 0; k < ISSUE_PORTS; k++) begin
      if (iss_valid[k]) pend_d[iss_addr[k]] = 1'b1;
    end
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic                  hit;
    logic                  use_byp;
    logic                  force_zero;
    logic [DATA_WIDTH-1:0] byp;

    regfile_sb_bypass #(
      .DATA_WIDTH  (DATA_WIDTH),
      .WRITE_PORTS (WRITE_PORTS),
      .ADDR_W      (ADDR_W)
    ) u_byp (
      .raddr  (raddr[i]),
      .we     (we),
      .waddr  (waddr),
      .wrdata (wrdata),
      .hit    (hit),
      .data   (byp)
    );

    assign use_byp    = (WRITE_THROUGH != 0) && hit;
    assign force_zero = rst || (raddr[i] == ZeroAddr);
    assign rddata[i]  = force_zero ? '0 : (use_byp ? byp : regs_q[raddr[i]]);
    assign rd_busy[i] = !force_zero && pend_q[raddr[i]] && !use_byp;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance share one stimulus.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            we;
  reg_addr_t [1:0]       waddr;
  logic [1:0][31:0]      wrdata;
  reg_addr_t [3:0]       raddr;
  logic [3:0][31:0]      rddata, rddata_nb;
  logic [3:0]            rd_busy, rd_busy_nb;
  logic [0:0]            iss_valid;
  reg_addr_t [0:0]       iss_addr;
  logic                  flush;

  always #5 clk = ~clk;

  regfile_sb #(.WRITE_THROUGH(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wrdata(wrdata), .raddr(raddr),
    .rddata(rddata), .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .flush(flush)
  );

  regfile_sb #(.WRITE_THROUGH(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wrdata(wrdata), .raddr(raddr),
    .rddata(rddata_nb), .rd_busy(rd_busy_nb), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .flush(flush)
  );

  // kind: 0 = rddata, 1 = rd_busy (bypassing dut); 2 = rddata, 3 = rd_busy (non-bypassing dut)
  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string tag, input int kind, input int port, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.port = port; e.exp = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind, input int port);
    case (kind)
      0:       return rddata[port];
      1:       return {31'd0, rd_busy[port]};
      2:       return rddata_nb[port];
      default: return {31'd0, rd_busy_nb[port]};
    endcase
  endfunction

  // Settle combinational outputs, then drain every queued expectation.
  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    #2;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.port);
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s kind%0d port%0d: observed %h expected %h", e.tag, e.kind, e.port,
               obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; iss_valid = '0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle(); waddr = '0; wrdata = '0; iss_addr = '0;
    raddr = '{5'd0, 5'd31, 5'd5, 5'd1};
    step(); step();
    // Write attempted while in reset must be dropped and outputs held at zero.
    we = 2'b01; waddr[0] = 5'd1; wrdata[0] = 32'hAAAA_5555;
    for (int i = 0; i < 4; i++) begin
      push("rst_data", 0, i, 32'h0);
      push("rst_busy", 1, i, 32'h0);
      push("rst_data_nb", 2, i, 32'h0);
    end
    check_all();
    step(); rst = 1'b0; idle();

    // Write and same-cycle bypass
    we = 2'b01; waddr[0] = 5'd3; wrdata[0] = 32'hDEAD_BEEF; raddr[0] = 5'd3; raddr[1] = 5'd1;
    push("wt_same", 0, 0, 32'hDEAD_BEEF);
    push("nb_same", 2, 0, 32'h0);
    push("rst_write_dropped", 0, 1, 32'h0);
    check_all();
    step(); idle();
    push("wt_next", 0, 0, 32'hDEAD_BEEF);
    push("nb_next", 2, 0, 32'hDEAD_BEEF);
    check_all();

    // Write-port priority
    we = 2'b11; waddr = '{5'd7, 5'd7}; wrdata = '{32'h22, 32'h11}; raddr[0] = 5'd7;
    push("prio_same", 0, 0, 32'h22);
    push("prio_same_nb", 2, 0, 32'h0);
    check_all();
    step(); idle();
    push("prio_next", 0, 0, 32'h22);
    push("prio_next_nb", 2, 0, 32'h22);
    check_all();

    // Register 0 guard
    we = 2'b01; waddr[0] = 5'd0; wrdata[0] = 32'hFFFF_FFFF; iss_valid = 1'b1; iss_addr[0] = 5'd0;
    raddr[0] = 5'd0;
    push("r0_same", 0, 0, 32'h0);
    push("r0_busy_same", 1, 0, 32'h0);
    check_all();
    step(); idle();
    push("r0_next", 0, 0, 32'h0);
    push("r0_busy_next", 1, 0, 32'h0);
    push("r0_next_nb", 2, 0, 32'h0);
    check_all();

    // Scoreboard lifecycle on r9
    iss_valid = 1'b1; iss_addr[0] = 5'd9; raddr[0] = 5'd9;
    push("iss_not_same_cycle", 1, 0, 32'h0);
    check_all();
    step(); idle();
    push("iss_busy", 1, 0, 32'h1);
    push("iss_busy_nb", 3, 0, 32'h1);
    check_all();
    we = 2'b01; waddr[0] = 5'd9; wrdata[0] = 32'h5;
    push("wb_busy_byp", 1, 0, 32'h0);
    push("wb_data_byp", 0, 0, 32'h5);
    push("wb_busy_nb", 3, 0, 32'h1);
    push("wb_data_nb", 2, 0, 32'h0);
    check_all();
    step(); idle();
    push("wb_released", 1, 0, 32'h0);
    push("wb_released_nb", 3, 0, 32'h0);
    push("wb_data_next", 0, 0, 32'h5);
    check_all();
    iss_valid = 1'b1; iss_addr[0] = 5'd9; we = 2'b01; waddr[0] = 5'd9; wrdata[0] = 32'h6;
    step(); idle();
    push("iss_beats_wb", 1, 0, 32'h1);
    push("iss_beats_wb_data", 0, 0, 32'h6);
    check_all();

    // Flush
    iss_valid = 1'b1;
    iss_addr[0] = 5'd4; step();
    iss_addr[0] = 5'd5; step();
    iss_addr[0] = 5'd6; step(); idle();
    raddr = '{5'd9, 5'd6, 5'd5, 5'd4};
    for (int i = 0; i < 4; i++) push("pre_flush_busy", 1, i, 32'h1);
    check_all();
    flush = 1'b1; iss_valid = 1'b1; iss_addr[0] = 5'd8;
    we = 2'b01; waddr[0] = 5'd4; wrdata[0] = 32'h9;
    raddr = '{5'd8, 5'd6, 5'd5, 5'd4};
    push("flush_same_r4", 1, 0, 32'h0);
    push("flush_same_r5", 1, 1, 32'h1);
    push("flush_same_r8", 1, 3, 32'h0);
    check_all();
    step(); idle();
    for (int i = 0; i < 4; i++) push("post_flush_busy", 1, i, 32'h0);
    push("post_flush_r4", 0, 0, 32'h9);
    check_all();
    raddr[0] = 5'd9;
    push("post_flush_r9", 1, 0, 32'h0);
    check_all();

    // Reset mid-operation overrides write and issue
    rst = 1'b1; we = 2'b01; waddr[0] = 5'd10; wrdata[0] = 32'h77; iss_valid = 1'b1;
    iss_addr[0] = 5'd11;
    step(); rst = 1'b0; idle();
    raddr = '{5'd3, 5'd7, 5'd11, 5'd10};
    push("mid_rst_r10", 0, 0, 32'h0);
    push("mid_rst_r11_busy", 1, 1, 32'h0);
    push("mid_rst_r7", 0, 2, 32'h0);
    push("mid_rst_r3", 0, 3, 32'h0);
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
